// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encodings, flag bit positions and the shifter
//                state type for the execute-stage ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t ALU_ADD    = 4'b0000;
    localparam opcode_t ALU_SUB    = 4'b0001;
    localparam opcode_t ALU_RED    = 4'b0010;
    localparam opcode_t ALU_XOR    = 4'b0011;
    localparam opcode_t ALU_SLL    = 4'b0100;
    localparam opcode_t ALU_SRA    = 4'b0101;
    localparam opcode_t ALU_ROR    = 4'b0110;
    localparam opcode_t ALU_PADDSB = 4'b0111;
    localparam opcode_t ALU_LW     = 4'b1000;
    localparam opcode_t ALU_SW     = 4'b1001;

    // Bit positions inside the {N,V,Z} flag vector
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // IDLE accepts new work; SHIFT iterates a multi-cycle shift/rotate
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/sat_add_lane.sv
`default_nettype none
// ============================================================================
//  Module      : sat_add_lane
//  Description : W-bit signed add/subtract with saturation to the signed
//                limits and an overflow indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_add_lane #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] w_b_eff;
    logic [W-1:0] w_raw;

    // Subtraction is a + ~b + 1, so overflow detection is identical for both
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_raw   = i_a + w_b_eff + {{(W-1){1'b0}}, i_sub};

    // Overflow: operands agree in sign but the raw sum does not
    assign o_ovf = (i_a[W-1] == w_b_eff[W-1]) && (w_raw[W-1] != i_a[W-1]);

    // On overflow the true result lies beyond the limit on the side of a's sign
    assign o_sum = o_ovf ? (i_a[W-1] ? c_min : c_max) : w_raw;

endmodule : sat_add_lane
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Handshaked execute-stage ALU with registered result/flags,
//                saturating arithmetic, packed lane add and an iterative
//                shifter/rotator that stalls intake while it runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LANE       = 4,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam int SHW     = $clog2(WIDTH);
    localparam int c_lanes = WIDTH / LANE;
    localparam int c_bytes = WIDTH / 8;
    localparam logic [SHW-1:0] c_step = SHW'(SHIFT_STEP);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [SHW-1:0] f_min_step(input logic [SHW-1:0] x);
        return (x < c_step) ? x : c_step;
    endfunction

    function automatic logic [WIDTH-1:0] f_shift_step(input opcode_t op,
                                                      input logic [WIDTH-1:0] val,
                                                      input logic [SHW-1:0] k);
        case (op)
            ALU_SLL: return val << k;
            ALU_SRA: return $signed(val) >>> k;
            default: return (val >> k) | (val << (WIDTH - int'(k)));
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_flags;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_remain;
    opcode_t          r_shift_op;

    logic             w_slot_free;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_load_result;
    logic [2:0]       w_load_flags;
    logic [WIDTH-1:0] w_work_next;
    logic [SHW-1:0]   w_remain_next;
    opcode_t          w_shift_op_next;

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = rst_n && (r_state == IDLE) && w_slot_free;
    assign w_accept    = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

    // ------------------------------------------------------------------
    // Arithmetic datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_addsub_sum;
    logic             w_addsub_ovf;

    sat_add_lane #(.W(WIDTH)) u_addsub (
        .i_a   (a),
        .i_b   (b),
        .i_sub (opcode == ALU_SUB),
        .o_sum (w_addsub_sum),
        .o_ovf (w_addsub_ovf)
    );

    // Packed lanes saturate independently; their overflow bits feed no flag
    logic [WIDTH-1:0]   w_paddsb;
    logic [c_lanes-1:0] w_lane_ovf_unused;

    for (genvar gi = 0; gi < c_lanes; gi++) begin : g_lane
        sat_add_lane #(.W(LANE)) u_lane (
            .i_a   (a[gi*LANE +: LANE]),
            .i_b   (b[gi*LANE +: LANE]),
            .i_sub (1'b0),
            .o_sum (w_paddsb[gi*LANE +: LANE]),
            .o_ovf (w_lane_ovf_unused[gi])
        );
    end

    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_addr;

    // Byte reduction: every byte of a and b sign-extended and summed
    always_comb begin
        w_red = '0;
        for (int i = 0; i < c_bytes; i++) begin
            w_red = w_red + WIDTH'($signed(a[8*i +: 8])) + WIDTH'($signed(b[8*i +: 8]));
        end
    end

    // Halfword-aligned base plus word offset for loads/stores
    assign w_addr = (a & ~WIDTH'(1)) + (b << 1);

    // ------------------------------------------------------------------
    // Single-cycle result/flag selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_alu_result;
    logic [2:0]       w_alu_flags;
    logic             w_is_shift;

    // Select the single-cycle result and its flag update by opcode
    always_comb begin
        w_alu_result = b;
        w_alu_flags  = r_flags;
        w_is_shift   = 1'b0;
        case (opcode)
            ALU_ADD, ALU_SUB: begin
                w_alu_result        = w_addsub_sum;
                w_alu_flags[FLAG_N] = w_addsub_sum[WIDTH-1];
                w_alu_flags[FLAG_V] = w_addsub_ovf;
                w_alu_flags[FLAG_Z] = (w_addsub_sum == '0);
            end
            ALU_RED:    w_alu_result = w_red;
            ALU_XOR: begin
                w_alu_result        = a ^ b;
                w_alu_flags[FLAG_Z] = ((a ^ b) == '0);
            end
            ALU_SLL, ALU_SRA, ALU_ROR: w_is_shift = 1'b1;
            ALU_PADDSB: w_alu_result = w_paddsb;
            ALU_LW, ALU_SW: w_alu_result = w_addr;
            default:    w_alu_result = b;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative shifter: first step on the accept edge, rest in SHIFT
    // ------------------------------------------------------------------
    logic [SHW-1:0]   w_shamt;
    logic [SHW-1:0]   w_acc_k;
    logic [WIDTH-1:0] w_acc_work;
    logic [SHW-1:0]   w_acc_remain;
    logic [SHW-1:0]   w_run_k;
    logic [WIDTH-1:0] w_run_work;
    logic [SHW-1:0]   w_run_remain;

    assign w_shamt      = b[SHW-1:0];
    assign w_acc_k      = f_min_step(w_shamt);
    assign w_acc_work   = f_shift_step(opcode, a, w_acc_k);
    assign w_acc_remain = w_shamt - w_acc_k;

    // Once remain hits zero the step is zero, so a blocked finish just holds
    assign w_run_k      = f_min_step(r_remain);
    assign w_run_work   = f_shift_step(r_shift_op, r_work, w_run_k);
    assign w_run_remain = r_remain - w_run_k;

    // Next-state and result-load decisions
    always_comb begin
        w_state_next    = r_state;
        w_load          = 1'b0;
        w_load_result   = w_alu_result;
        w_load_flags    = w_alu_flags;
        w_work_next     = r_work;
        w_remain_next   = r_remain;
        w_shift_op_next = r_shift_op;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_shift) begin
                        w_shift_op_next = opcode;
                        w_work_next     = w_acc_work;
                        w_remain_next   = w_acc_remain;
                        if (w_acc_remain == '0) begin
                            w_load               = 1'b1;
                            w_load_result        = w_acc_work;
                            w_load_flags         = r_flags;
                            w_load_flags[FLAG_Z] = (w_acc_work == '0);
                        end else begin
                            w_state_next = SHIFT;
                        end
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            SHIFT: begin
                w_work_next   = w_run_work;
                w_remain_next = w_run_remain;
                if ((w_run_remain == '0) && w_slot_free) begin
                    w_load               = 1'b1;
                    w_load_result        = w_run_work;
                    w_load_flags         = r_flags;
                    w_load_flags[FLAG_Z] = (w_run_work == '0);
                    w_state_next         = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output slot, flags and shifter working registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_work      <= '0;
            r_remain    <= '0;
            r_shift_op  <= ALU_ADD;
        end else begin
            r_work      <= w_work_next;
            r_remain    <= w_remain_next;
            r_shift_op  <= w_shift_op_next;
            r_out_valid <= w_load || (r_out_valid && !out_ready);
            if (w_load) begin
                r_result <= w_load_result;
                r_flags  <= w_load_flags;
            end
        end
    end

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Directed self-checking bench for alu_exec_unit
//                (WIDTH=16, LANE=4, SHIFT_STEP=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'b0000;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [2:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.WIDTH(16), .LANE(4), .SHIFT_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Present one op, wait (bounded) for acceptance, return at the next negedge
    task automatic do_op(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
        int waited;
        waited = 0;
        opcode = op; a = va; b = vb; in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Count cycles (bounded) until out_valid, also counting in_ready-low cycles
    task automatic wait_out(output int lat, output int low);
        lat = 1; low = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) low++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
        n_tests++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", flags); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
        rst_n = 1'b1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_high: got %b want 1", in_ready); end
    endtask

    task automatic test_add_sat;
        do_op(4'b0000, 16'h7FFF, 16'h0001);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: out_valid=%b want 1", out_valid); end
        n_tests++; if (result !== 16'h7FFF) begin n_fail++; $display("FAIL add_sat_result: got %h want 7fff", result); end
        n_tests++; if (flags !== 3'b010) begin n_fail++; $display("FAIL add_sat_flags: got %b want 010", flags); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_consume: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_logic_ops;
        do_op(4'b0001, 16'h0005, 16'h0005);
        n_tests++; if (result !== 16'h0000 || flags !== 3'b001) begin n_fail++; $display("FAIL sub_zero: got %h/%b want 0000/001", result, flags); end
        do_op(4'b0001, 16'h8000, 16'h0001);
        n_tests++; if (result !== 16'h8000 || flags !== 3'b110) begin n_fail++; $display("FAIL sub_sat_neg: got %h/%b want 8000/110", result, flags); end
        do_op(4'b0011, 16'h00FF, 16'h00FF);
        n_tests++; if (result !== 16'h0000 || flags !== 3'b111) begin n_fail++; $display("FAIL xor_zero: got %h/%b want 0000/111", result, flags); end
        do_op(4'b0010, 16'h7F7F, 16'h7F7F);
        n_tests++; if (result !== 16'h01FC || flags !== 3'b111) begin n_fail++; $display("FAIL red: got %h/%b want 01fc/111", result, flags); end
        do_op(4'b0010, 16'h80FF, 16'h0102);
        n_tests++; if (result !== 16'hFF82 || flags !== 3'b111) begin n_fail++; $display("FAIL red_neg: got %h/%b want ff82/111", result, flags); end
        do_op(4'b0011, 16'h1234, 16'h0000);
        n_tests++; if (result !== 16'h1234 || flags !== 3'b110) begin n_fail++; $display("FAIL xor_nz: got %h/%b want 1234/110", result, flags); end
    endtask

    task automatic test_shift;
        int lat, low;
        do_op(4'b0110, 16'h8001, 16'h0004);
        wait_out(lat, low);
        n_tests++; if (lat != 4) begin n_fail++; $display("FAIL ror_latency: got %0d want 4", lat); end
        n_tests++; if (low != 3) begin n_fail++; $display("FAIL ror_in_ready_low: got %0d want 3", low); end
        n_tests++; if (result !== 16'h1800 || flags !== 3'b110) begin n_fail++; $display("FAIL ror: got %h/%b want 1800/110", result, flags); end
        do_op(4'b0101, 16'h8000, 16'h000F);
        wait_out(lat, low);
        n_tests++; if (lat != 15) begin n_fail++; $display("FAIL sra_latency: got %0d want 15", lat); end
        n_tests++; if (result !== 16'hFFFF) begin n_fail++; $display("FAIL sra: got %h want ffff", result); end
        do_op(4'b0100, 16'h0003, 16'h0000);
        wait_out(lat, low);
        n_tests++; if (lat != 1 || result !== 16'h0003) begin n_fail++; $display("FAIL sll_zero_shamt: got %h lat %0d want 0003 lat 1", result, lat); end
        do_op(4'b0100, 16'h8000, 16'h0001);
        wait_out(lat, low);
        n_tests++; if (result !== 16'h0000 || flags !== 3'b111) begin n_fail++; $display("FAIL sll_z: got %h/%b want 0000/111", result, flags); end
        do_op(4'b0100, 16'h0001, 16'h0013);
        wait_out(lat, low);
        n_tests++; if (lat != 3 || result !== 16'h0008 || flags !== 3'b110) begin n_fail++; $display("FAIL sll_shamt_mask: got %h/%b lat %0d want 0008/110 lat 3", result, flags, lat); end
    endtask

    task automatic test_paddsb;
        do_op(4'b0111, 16'h7878, 16'h1111);
        n_tests++; if (result !== 16'h7979 || flags !== 3'b110) begin n_fail++; $display("FAIL paddsb_pos: got %h/%b want 7979/110", result, flags); end
        do_op(4'b0111, 16'h8F00, 16'h8F00);
        n_tests++; if (result !== 16'h8E00) begin n_fail++; $display("FAIL paddsb_neg: got %h want 8e00", result); end
    endtask

    task automatic test_mem_default;
        do_op(4'b1000, 16'h1001, 16'h0010);
        n_tests++; if (result !== 16'h1020) begin n_fail++; $display("FAIL lw: got %h want 1020", result); end
        do_op(4'b1001, 16'hFFFF, 16'h8001);
        n_tests++; if (result !== 16'h0000 || flags !== 3'b110) begin n_fail++; $display("FAIL sw_wrap: got %h/%b want 0000/110", result, flags); end
        do_op(4'b1111, 16'h1234, 16'hABCD);
        n_tests++; if (result !== 16'hABCD || flags !== 3'b110) begin n_fail++; $display("FAIL op_pass_b: got %h/%b want abcd/110", result, flags); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0;
        do_op(4'b0000, 16'h0001, 16'h0002);
        n_tests++; if (out_valid !== 1'b1 || result !== 16'h0003 || flags !== 3'b000) begin n_fail++; $display("FAIL bp_first: got %b %h/%b want 1 0003/000", out_valid, result, flags); end
        opcode = 4'b0000; a = 16'h4000; b = 16'h4000; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 16'h0003 || flags !== 3'b000) begin
                n_fail++; $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b %h/%b want 0 1 0003/000", i, in_ready, out_valid, result, flags);
            end
        end
        out_ready = 1'b1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || result !== 16'h7FFF || flags !== 3'b010) begin n_fail++; $display("FAIL bp_second: got %b %h/%b want 1 7fff/010", out_valid, result, flags); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        opcode = 4'b0000; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || result !== 16'h0002) begin n_fail++; $display("FAIL b2b_0: got %b %h want 1 0002", out_valid, result); end
        a = 16'h0002; b = 16'h0003;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || result !== 16'h0005) begin n_fail++; $display("FAIL b2b_1: got %b %h want 1 0005", out_valid, result); end
        opcode = 4'b0001; a = 16'h0003; b = 16'h0005;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || result !== 16'hFFFE || flags !== 3'b100) begin n_fail++; $display("FAIL b2b_2: got %b %h/%b want 1 fffe/100", out_valid, result, flags); end
    endtask

    task automatic test_reset_mid_shift;
        int stale;
        @(negedge clk);
        do_op(4'b0100, 16'h0001, 16'h0008);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0 || result !== 16'h0000 || flags !== 3'b000 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midshift_reset: got %b %h/%b ready %b want 0 0000/000 ready 0", out_valid, result, flags, in_ready);
        end
        rst_n = 1'b1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midshift_ready: got %b want 1", in_ready); end
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_tests++; if (stale != 0) begin n_fail++; $display("FAIL midshift_stale: %0d valid cycles want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_add_sat();
        test_logic_ops();
        test_shift();
        test_paddsb();
        test_mem_default();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire
